mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between the fetch stage (read-only) and the load/store path (read/write).
- Sits between IF/MEM stages and the memory. Stage stalls are derived from missing acks.
- Data has priority, with a starvation guard for fetch.
- Handles fetch cancellation on a taken branch or jump, and rejects misaligned fetches.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int WSTRB_W          = 4;
  localparam int DEF_MAX_D_STREAK = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision for the shared memory port, evaluated only while the arbiter is idle.
// Data normally wins; once the data streak is full, a pending fetch wins instead.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  logic    i_flush,
  input  logic    streak_full,
  output logic    grant_valid,
  output req_id_e grant_id
);

  // Priority pick: data unless fetch is being starved, fetch unless it is being flushed.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_I;
    if (d_req && (!i_req || !streak_full)) begin
      grant_valid = 1'b1;
      grant_id    = REQ_D;
    end else if (i_req && !i_flush) begin
      grant_valid = 1'b1;
      grant_id    = REQ_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported instruction/data memory between fetch and load/store.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | sampling requests, deciding the next grant
//   BUSY_I | fetch access in flight, mem_valid held until mem_ready
//   BUSY_D | load/store access in flight, mem_valid held until mem_ready
//   RESP   | one-cycle ack to the owner of the finished access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_flush,
  output logic               i_ack,
  output logic               i_err,
  output logic [DATA_W-1:0]  i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic [WSTRB_W-1:0] d_wstrb,
  output logic               d_ack,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               mem_valid,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [ADDR_W-1:0]   WORD_MASK  = ~ADDR_W'(3);

  state_e               state_q, state_d;
  req_id_e              resp_id_q, resp_id_d;
  logic                 err_q, err_d;
  logic                 flush_q, flush_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]    i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;

  logic    grant_valid;
  req_id_e grant_id;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .i_flush     (i_flush),
    .streak_full (streak_q == STREAK_MAX),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state and datapath register updates for the access sequencer.
  always_comb begin
    state_d     = state_q;
    resp_id_d   = resp_id_q;
    err_d       = err_q;
    flush_d     = flush_q;
    streak_d    = streak_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid && (grant_id == REQ_D)) begin
          state_d     = BUSY_D;
          resp_id_d   = REQ_D;
          err_d       = 1'b0;
          mem_valid_d = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr & WORD_MASK;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_we ? d_wstrb : '0;
          // Only count data wins that actually held off a waiting fetch.
          if (!i_req)                     streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (grant_valid) begin
          resp_id_d = REQ_I;
          streak_d  = '0;
          if (i_addr[1:0] != 2'b00) begin
            // Misaligned fetch is answered with an error, memory is never touched.
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = BUSY_I;
            err_d       = 1'b0;
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr & WORD_MASK;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end
      BUSY_I: begin
        // A flushed fetch still has to finish on the bus; only its ack is dropped.
        if (i_flush) flush_d = 1'b1;
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          i_rdata_d   = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          d_rdata_d   = mem_rdata;
        end
      end
      RESP: begin
        // A flush arriving on this cycle is handled directly in the ack gating.
        state_d = IDLE;
        flush_d = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath flops; async reset drops mem_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      resp_id_q   <= REQ_I;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      streak_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      resp_id_q   <= resp_id_d;
      err_q       <= err_d;
      flush_q     <= flush_d;
      streak_q    <= streak_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_ack     = (state_q == RESP) && (resp_id_q == REQ_I) && !flush_q && !i_flush;
  assign i_err     = i_ack && err_q;
  assign d_ack     = (state_q == RESP) && (resp_id_q == REQ_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tests queue expected memory accesses and acks,
// a memory model and an ack monitor pop and compare them as the DUT presents them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int i_ack_cnt = 0;
  int d_ack_cnt = 0;
  int mem_valid_cyc = 0;
  int mem_delay = 0;

  logic [33:0] i_q[$];   // {err, check_data, data}
  logic [32:0] d_q[$];   // {check_data, data}
  logic [68:0] m_q[$];   // {we, addr, wdata, wstrb}
  logic [31:0] mem_arr [logic [31:0]];
  logic [33:0] ie;
  logic [32:0] de;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'h0BAD_0000 | {16'h0, a[15:0]};
  endfunction

  // Ack monitor: every ack must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_ack) begin
        i_ack_cnt++;
        if (i_q.size() == 0) fail("i_ack_unexpected");
        else begin
          ie = i_q.pop_front();
          chk("i_err", {79'h0, i_err}, {79'h0, ie[33]});
          if (ie[32]) chk("i_rdata", {48'h0, i_rdata}, {48'h0, ie[31:0]});
        end
      end
      if (d_ack) begin
        d_ack_cnt++;
        if (d_q.size() == 0) fail("d_ack_unexpected");
        else begin
          de = d_q.pop_front();
          if (de[32]) chk("d_rdata", {48'h0, d_rdata}, {48'h0, de[31:0]});
        end
      end
    end
  end

  // Memory model: responds after mem_delay stall cycles, checks request stability and content.
  initial begin
    int cnt;
    logic [68:0] snap, e;
    logic [31:0] w;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !mem_valid) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else begin
        if (cnt == 0) snap = {mem_we, mem_addr, mem_wdata, mem_wstrb};
        else chk("mem_stable", {11'h0, mem_we, mem_addr, mem_wdata, mem_wstrb}, {11'h0, snap});
        cnt++;
        mem_valid_cyc++;
        if (cnt > mem_delay) begin
          mem_ready = 1'b1;
          if (m_q.size() == 0) fail("mem_unexpected");
          else begin
            e = m_q.pop_front();
            chk("mem_req", {43'h0, mem_we, mem_addr, mem_wstrb}, {43'h0, e[68], e[67:36], e[3:0]});
            if (e[68]) chk("mem_wdata", {48'h0, mem_wdata}, {48'h0, e[35:4]});
          end
          if (mem_we) begin
            w = rd(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr] = w;
            mem_rdata = '0;
          end else begin
            mem_rdata = rd(mem_addr);
          end
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input int delay, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat);
    int cyc;
    mem_delay = delay;
    if (!exp_err) m_q.push_back({1'b0, addr, 32'h0, 4'h0});
    i_q.push_back({exp_err, !exp_err, exp_data});
    @(posedge clk); #1;
    i_addr = addr;
    i_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!i_ack && cyc < 40);
    chk("fetch_latency", 80'(cyc), 80'(exp_lat));
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay, input logic [31:0] exp_data,
                         input int exp_lat);
    int cyc;
    mem_delay = delay;
    m_q.push_back({we, addr, wdata, we ? wstrb : 4'h0});
    d_q.push_back({!we, exp_data});
    @(posedge clk); #1;
    d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    d_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!d_ack && cyc < 40);
    chk("data_latency", 80'(cyc), 80'(exp_lat));
    @(posedge clk); #1;
    d_req = 1'b0;
    d_we = 1'b0;
  endtask

  initial begin
    int i0, d0, v0, base, cyc;
    #12;
    chk("rst_mem_valid", {79'h0, mem_valid}, 80'h0);
    chk("rst_acks", {78'h0, i_ack, d_ack}, 80'h0);
    chk("rst_mem_bus", {11'h0, mem_we, mem_addr, mem_wdata, mem_wstrb}, 80'h0);
    chk("rst_rdata", {16'h0, i_rdata, d_rdata}, 80'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned fetch, zero-wait memory.
    mem_arr[32'h10] = 32'h0050_0093;
    do_fetch(32'h10, 0, 32'h0050_0093, 1'b0, 3);

    // Store with 4 stall cycles.
    i0 = i_ack_cnt; d0 = d_ack_cnt; v0 = mem_valid_cyc;
    do_data(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, 4, 32'h0, 7);
    repeat (3) @(posedge clk);
    chk("store_valid_cycles", 80'(mem_valid_cyc - v0), 80'd5);
    chk("store_d_acks", 80'(d_ack_cnt - d0), 80'd1);
    chk("store_no_i_ack", 80'(i_ack_cnt - i0), 80'd0);

    // Both requesters held: starvation guard gives D,D,D,D,I,D,D,D,D,I.
    mem_delay = 0;
    mem_arr[32'h200] = 32'h2222_2222;
    mem_arr[32'h300] = 32'h3333_3333;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        m_q.push_back({1'b0, 32'h300, 32'h0, 4'h0});
        i_q.push_back({1'b0, 1'b1, 32'h3333_3333});
      end else begin
        m_q.push_back({1'b0, 32'h200, 32'h0, 4'h0});
        d_q.push_back({1'b1, 32'h2222_2222});
      end
    end
    base = i_ack_cnt + d_ack_cnt;
    @(posedge clk); #1;
    i_addr = 32'h300; d_addr = 32'h200; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    i_req = 1'b1; d_req = 1'b1;
    cyc = 0;
    while ((i_ack_cnt + d_ack_cnt - base) < 10 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    i_req = 1'b0; d_req = 1'b0;
    chk("grant_ack_total", 80'(i_ack_cnt + d_ack_cnt - base), 80'd10);
    chk("grant_mem_drained", 80'(m_q.size()), 80'd0);

    // Fetch flushed in its 2nd BUSY cycle: access completes, no ack.
    repeat (2) @(posedge clk);
    i0 = i_ack_cnt;
    mem_delay = 2;
    m_q.push_back({1'b0, 32'h40, 32'h0, 4'h0});
    @(posedge clk); #1;
    i_addr = 32'h40; i_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    i_flush = 1'b1; i_req = 1'b0;
    @(posedge clk); #1;
    i_flush = 1'b0;
    repeat (4) @(posedge clk);
    chk("flush_no_i_ack", 80'(i_ack_cnt - i0), 80'd0);
    chk("flush_mem_done", 80'(m_q.size()), 80'd0);
    mem_arr[32'h20] = 32'h1234_5678;
    do_fetch(32'h20, 0, 32'h1234_5678, 1'b0, 3);

    // Misaligned fetch: error ack after 2 cycles, no memory access.
    v0 = mem_valid_cyc;
    do_fetch(32'h12, 0, 32'h0, 1'b1, 2);
    repeat (2) @(posedge clk);
    chk("misaligned_no_mem", 80'(mem_valid_cyc - v0), 80'd0);

    // Reset in the middle of a load.
    d0 = d_ack_cnt;
    mem_delay = 10;
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", {79'h0, mem_valid}, 80'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_valid", {79'h0, mem_valid}, 80'h0);
    chk("rst_d_rdata", {48'h0, d_rdata}, 80'h0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("rst_no_d_ack", 80'(d_ack_cnt - d0), 80'd0);
    mem_arr[32'h84] = 32'h8484_8484;
    do_data(1'b0, 32'h84, 32'h0, 4'h0, 1, 32'h8484_8484, 4);

    repeat (3) @(posedge clk);
    chk("queues_empty", 80'(i_q.size() + d_q.size() + m_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
